// File: rtl/oa211_bist_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | oa211_bist_pkg : shared types and constants for the oa211 cell self-check   |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
package oa211_bist_pkg;

  localparam int          VEC_W       = 4;
  localparam logic [15:0] OA211_TRUTH = 16'h777F;
  localparam logic [7:0]  MISR_POLY   = 8'h1D;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/oa211_bist_misr.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | oa211_bist_misr : 8-bit serial signature register, x^8+x^4+x^3+x^2+1        |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module oa211_bist_misr
  import oa211_bist_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       seed,
  input  logic       shift,
  input  logic       din,
  output logic [7:0] sig
);

  logic [7:0] sig_q, sig_d;
  logic       fb;

  always_comb begin
    sig_d = sig_q;
    fb    = sig_q[7] ^ din;
    if (seed) begin
      sig_d = 8'hFF;
    end else if (shift) begin
      sig_d = {sig_q[6:0], 1'b0} ^ (fb ? MISR_POLY : 8'h00);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_q <= 8'h00;
    else     sig_q <= sig_d;
  end

  assign sig = sig_q;

endmodule
`default_nettype wire

// File: rtl/oa211_bist.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | oa211_bist : walks all 16 vectors through an oa211 cell and checks Y.       |
// | Define OA211_BIST_MISR_EN to add an 8-bit response signature port.         |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module oa211_bist
  import oa211_bist_pkg::*;
#(
  parameter int          SETTLE_CYC   = 2,
  parameter logic [15:0] TRUTH        = OA211_TRUTH,
  parameter bit          STOP_ON_FAIL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             cell_a,
  output logic             cell_b,
  output logic             cell_c,
  output logic             cell_d,
  input  logic             cell_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [VEC_W-1:0] fail_idx,
  output logic             fail_y
`ifdef OA211_BIST_MISR_EN
  ,
  output logic [7:0]       signature
`endif
);

  localparam logic [3:0]       SETTLE_LD = 4'(SETTLE_CYC - 1);
  localparam logic [VEC_W-1:0] LAST_IDX  = {VEC_W{1'b1}};

  state_e           state_q, state_d;
  logic [VEC_W-1:0] idx_q, idx_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic [VEC_W-1:0] fail_idx_q, fail_idx_d;
  logic             fail_y_q, fail_y_d;
  logic             mismatch;
  logic             start_ok;

  // Case inequality so an X/Z on the cell output is flagged in simulation
  assign mismatch = (cell_y !== TRUTH[idx_q]);
  assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    vec_d      = vec_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    fail_idx_d = fail_idx_q;
    fail_y_d   = fail_y_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = DRIVE;
          idx_d      = '0;
          vec_d      = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          fail_d     = 1'b0;
          fail_idx_d = '0;
          fail_y_d   = 1'b0;
        end
      end
      DRIVE: begin
        cnt_d   = SETTLE_LD;
        state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == 4'd0) state_d = SAMPLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      SAMPLE: begin
        if (mismatch) begin
          fail_d = 1'b1;
          if (!fail_q) begin
            fail_idx_d = idx_q;
            fail_y_d   = cell_y;
          end
        end
        if ((STOP_ON_FAIL && mismatch) || (idx_q == LAST_IDX)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = ~(fail_q | mismatch);
        end else begin
          idx_d   = idx_q + 1'b1;
          vec_d   = idx_q + 1'b1;
          state_d = DRIVE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      vec_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      fail_idx_q <= '0;
      fail_y_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      vec_q      <= vec_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      fail_idx_q <= fail_idx_d;
      fail_y_q   <= fail_y_d;
    end
  end

  assign {cell_a, cell_b, cell_c, cell_d} = vec_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign fail_idx = fail_idx_q;
  assign fail_y   = fail_y_q;

`ifdef OA211_BIST_MISR_EN
  oa211_bist_misr u_misr (
    .clk   (clk),
    .rst   (rst),
    .seed  (start_ok),
    .shift (state_q == SAMPLE),
    .din   (cell_y),
    .sig   (signature)
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_oa211_bist.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_oa211_bist : directed bench for oa211_bist (stop and run-through builds) |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_oa211_bist;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_s = 1'b0, start_n = 1'b0;
  int   mode = 0;   // 0 good cell, 1 Y stuck-at-1, 2 Y inverted at vector 11
  int   total = 0, bad = 0;

  logic a_s, b_s, c_s, d_s, y_s, busy_s, done_s, pass_s, fy_s;
  logic a_n, b_n, c_n, d_n, y_n, busy_n, done_n, pass_n, fy_n;
  logic [3:0] fidx_s, fidx_n, vec_s, vec_n;
`ifdef OA211_BIST_MISR_EN
  logic [7:0] sig_s, sig_n;
`endif

  always #5 clk = ~clk;

  function automatic logic golden(input logic [3:0] v);
    return ~((v[3] | v[2]) & v[1] & v[0]);
  endfunction

  assign vec_s = {a_s, b_s, c_s, d_s};
  assign vec_n = {a_n, b_n, c_n, d_n};
  assign y_s = (mode == 1) ? 1'b1 : (golden(vec_s) ^ (mode == 2 && vec_s == 4'd11));
  assign y_n = (mode == 1) ? 1'b1 : (golden(vec_n) ^ (mode == 2 && vec_n == 4'd11));

  oa211_bist #(.SETTLE_CYC(2), .STOP_ON_FAIL(1'b1)) dut_s (
    .clk(clk), .rst(rst), .start(start_s),
    .cell_a(a_s), .cell_b(b_s), .cell_c(c_s), .cell_d(d_s), .cell_y(y_s),
    .busy(busy_s), .done(done_s), .pass(pass_s), .fail_idx(fidx_s), .fail_y(fy_s)
`ifdef OA211_BIST_MISR_EN
    , .signature(sig_s)
`endif
  );

  oa211_bist #(.SETTLE_CYC(2), .STOP_ON_FAIL(1'b0)) dut_n (
    .clk(clk), .rst(rst), .start(start_n),
    .cell_a(a_n), .cell_b(b_n), .cell_c(c_n), .cell_d(d_n), .cell_y(y_n),
    .busy(busy_n), .done(done_n), .pass(pass_n), .fail_idx(fidx_n), .fail_y(fy_n)
`ifdef OA211_BIST_MISR_EN
    , .signature(sig_n)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Leaves the bench on the first negedge after the accepted start edge
  task automatic pulse_start(input bit nf);
    @(negedge clk);
    if (nf) start_n = 1'b1; else start_s = 1'b1;
    @(negedge clk);
    start_n = 1'b0;
    start_s = 1'b0;
  endtask

  task automatic measure(input bit nf, input bit inject, input bit chk_vec, output int cycles);
    int vec_err;
    vec_err = 0;
    cycles  = 0;
    while ((nf ? busy_n : busy_s) && cycles < 200) begin
      if ((nf ? vec_n : vec_s) != 4'(cycles / 4)) vec_err++;
      if ((nf ? done_n : done_s) !== 1'b0) vec_err++;
      if (inject) start_s = (cycles == 10 || cycles == 40);
      cycles++;
      @(negedge clk);
    end
    start_s = 1'b0;
    if (chk_vec) chk("vec_order", vec_err, 0);
  endtask

`ifdef OA211_BIST_MISR_EN
  function automatic logic [7:0] misr_model(input int flip_at);
    logic [7:0] s;
    logic       y, fb;
    s = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      y  = golden(4'(i)) ^ (i == flip_at);
      fb = s[7] ^ y;
      s  = {s[6:0], 1'b0} ^ (fb ? 8'h1D : 8'h00);
    end
    return s;
  endfunction
`endif

  initial begin
    int cyc;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {busy_s, done_s, pass_s, fidx_s, fy_s, vec_s}, 0);
    chk("rst_outputs_nf", {busy_n, done_n, pass_n, fidx_n, fy_n, vec_n}, 0);
    rst = 1'b0;

    // Good cell, full run
    mode = 0;
    pulse_start(1'b0);
    measure(1'b0, 1'b0, 1'b1, cyc);
    chk("good_cycles", cyc, 64);
    chk("good_done_pass", {busy_s, done_s, pass_s}, 3'b011);
    chk("good_last_vec", vec_s, 15);

    // Stuck-at-1, stop on first failure (restart from DONE)
    mode = 1;
    pulse_start(1'b0);
    measure(1'b0, 1'b0, 1'b0, cyc);
    chk("stop_cycles", cyc, 32);
    chk("stop_done_pass", {busy_s, done_s, pass_s}, 3'b010);
    chk("stop_fail_idx", fidx_s, 7);
    chk("stop_fail_y", fy_s, 1);
    chk("stop_vec_hold", vec_s, 7);

    // Stuck-at-1, run through all vectors
    pulse_start(1'b1);
    measure(1'b1, 1'b0, 1'b0, cyc);
    chk("run_cycles", cyc, 64);
    chk("run_done_pass", {busy_n, done_n, pass_n}, 3'b010);
    chk("run_fail_idx", fidx_n, 7);
    chk("run_fail_y", fy_n, 1);

    // Reset asserted during vector 5 settle
    mode = 0;
    pulse_start(1'b0);
    repeat (21) @(negedge clk);
    chk("pre_rst_state", {busy_s, vec_s}, {1'b1, 4'd5});
    #2 rst = 1'b1;
    #1;
    chk("async_rst", {busy_s, done_s, pass_s, fidx_s, fy_s, vec_s}, 0);
    @(negedge clk);
    rst = 1'b0;
    pulse_start(1'b0);
    measure(1'b0, 1'b0, 1'b1, cyc);
    chk("post_rst_cycles", cyc, 64);
    chk("post_rst_pass", {done_s, pass_s}, 2'b11);

    // start pulses while busy are ignored
    pulse_start(1'b0);
    measure(1'b0, 1'b1, 1'b1, cyc);
    chk("busy_start_cycles", cyc, 64);
    chk("busy_start_pass", {done_s, pass_s}, 2'b11);

    // start while DONE restarts on the next edge
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    chk("done_restart", {busy_s, done_s, pass_s, vec_s}, {3'b100, 4'd0});
    measure(1'b0, 1'b0, 1'b1, cyc);
    chk("restart_cycles", cyc, 64);
    chk("restart_pass", {done_s, pass_s}, 2'b11);

`ifdef OA211_BIST_MISR_EN
    mode = 0;
    pulse_start(1'b1);
    measure(1'b1, 1'b0, 1'b0, cyc);
    chk("sig_good", sig_n, misr_model(-1));
    @(negedge clk);
    chk("sig_stable", sig_n, misr_model(-1));
    mode = 2;
    pulse_start(1'b1);
    measure(1'b1, 1'b0, 1'b0, cyc);
    chk("sig_flip11", sig_n, misr_model(11));
    chk("sig_flip_differs", (sig_n != misr_model(-1)), 1);
    chk("flip_fail_idx", {pass_n, fidx_n}, {1'b0, 4'd11});
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
